stage_evaluator: RTL and testbench

- Consumer end of the weak-classifier result interface (feature_value / fvalue_valid) in the Haar cascade datapath.
- Accumulates signed weak-classifier votes for the current stage and compares the stage sum against the stage threshold.
- Advances through cascade stages and drives op_done back to the classifiers.
- Reports a per-window face/no-face decision.

---
 rtl/haar_pkg.sv | 46 ++++
 rtl/sat_accumulator.sv | 42 ++++
 rtl/stage_evaluator.sv | 125 ++++++++++++
 tb/tb_stage_evaluator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/haar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : haar_pkg
// Description : Shared constants, FSM state encodings and the saturating-add
//               helper for the Haar cascade datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package haar_pkg;

  localparam int DATA_W     = 16;
  localparam int ACC_W      = 24;
  localparam int NUM_STAGES = 25;
  localparam int STAGE_W    = 5;
  localparam int WC_W       = 9;

  // Stage-evaluator state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Signed add clamped to the limits of a 'width'-bit two's complement value.
  // Operands arrive sign-extended to 64 bits so one helper serves every
  // accumulator width up to 62 bits without overflowing the raw sum.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    if (sum > hi) begin
      res = hi;
    end else if (sum < lo) begin
      res = lo;
    end else begin
      res = sum;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sat_accumulator
// Description : Signed saturating accumulate register with synchronous clear.
//               Clear has priority over accumulate.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_accumulator #(
  parameter int WIDTH = 24,
  parameter int IN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  addend,
  output logic signed [WIDTH-1:0] acc
);
  import haar_pkg::*;

  logic signed [63:0]      acc_ext;
  logic signed [63:0]      add_ext;
  logic signed [WIDTH-1:0] sum_sat;

  // Widen both operands so the clamp sees the true, unwrapped sum
  assign acc_ext = {{(64-WIDTH){acc[WIDTH-1]}}, acc};
  assign add_ext = {{(64-IN_W){addend[IN_W-1]}}, addend};
  assign sum_sat = WIDTH'(sat_add(acc_ext, add_ext, WIDTH));

  // Accumulator register: clear wins, otherwise add when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_sat;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stage_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : stage_evaluator
// Description : Accumulates weak-classifier votes per cascade stage, compares
//               the stage sum against the stage threshold, walks the cascade
//               and reports a per-window face / no-face decision.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_evaluator #(
  parameter int DATA_W     = haar_pkg::DATA_W,
  parameter int ACC_W      = haar_pkg::ACC_W,
  parameter int NUM_STAGES = haar_pkg::NUM_STAGES,
  parameter int STAGE_W    = haar_pkg::STAGE_W,
  parameter int WC_W       = haar_pkg::WC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  feature_value,
  input  logic               fvalue_valid,
  input  logic [WC_W-1:0]    stage_wc_count,
  input  logic [DATA_W-1:0]  stage_threshold,
  output logic [STAGE_W-1:0] stage_idx,
  output logic [WC_W-1:0]    wc_idx,
  output logic               op_done,
  output logic               busy,
  output logic               window_done,
  output logic               face_detected
);
  import haar_pkg::*;

  logic [1:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] thr_ext;
  logic                    stage_pass;
  logic                    last_stage;
  logic                    last_vote;
  logic                    empty_stage;
  logic                    vote_en;
  logic                    acc_clear;

  assign thr_ext     = {{(ACC_W-DATA_W){stage_threshold[DATA_W-1]}}, stage_threshold};
  assign stage_pass  = (acc >= thr_ext);
  assign last_stage  = (stage_idx == STAGE_W'(NUM_STAGES - 1));
  assign empty_stage = (stage_wc_count == '0);
  assign last_vote   = (wc_idx == (stage_wc_count - 1'b1));

  // A vote is consumed only in ACCUM; an empty stage consumes nothing
  assign vote_en   = (state == ST_ACCUM) && fvalue_valid && !empty_stage;
  // Fresh sum at window start and whenever a non-final stage passes
  assign acc_clear = ((state == ST_IDLE) && start) ||
                     ((state == ST_COMPARE) && stage_pass && !last_stage);

  assign busy        = (state == ST_ACCUM) || (state == ST_COMPARE);
  assign window_done = (state == ST_DONE);

  sat_accumulator #(
    .WIDTH (ACC_W),
    .IN_W  (DATA_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .en     (vote_en),
    .addend (feature_value),
    .acc    (acc)
  );

  // Cascade sequencer: stage/vote counters, handshake and decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      stage_idx     <= '0;
      wc_idx        <= '0;
      op_done       <= 1'b1;
      face_detected <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          op_done <= 1'b1;
          if (start) begin
            stage_idx     <= '0;
            wc_idx        <= '0;
            face_detected <= 1'b0;
            op_done       <= 1'b0;
            state         <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (empty_stage) begin
            op_done <= 1'b1;
            state   <= ST_COMPARE;
          end else if (fvalue_valid) begin
            wc_idx <= wc_idx + 1'b1;
            if (last_vote) begin
              op_done <= 1'b1;
              state   <= ST_COMPARE;
            end
          end
        end
        ST_COMPARE: begin
          if (stage_pass && !last_stage) begin
            stage_idx <= stage_idx + 1'b1;
            wc_idx    <= '0;
            op_done   <= 1'b0;
            state     <= ST_ACCUM;
          end else begin
            // Final stage passed, or early reject on any stage
            face_detected <= stage_pass;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          op_done <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_evaluator
// Description : Directed self-checking bench for stage_evaluator. A second
//               instance with a two-stage cascade shares all inputs and is
//               checked only in the full-cascade face scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stage_evaluator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] feature_value = '0;
  logic        fvalue_valid = 1'b0;
  logic [8:0]  stage_wc_count = '0;
  logic [15:0] stage_threshold = '0;

  logic [4:0]  stage_idx,  stage_idx2;
  logic [8:0]  wc_idx,     wc_idx2;
  logic        op_done,    op_done2;
  logic        busy,       busy2;
  logic        window_done, window_done2;
  logic        face_detected, face_detected2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_evaluator u_dut (
    .clk (clk), .rst (rst), .start (start),
    .feature_value (feature_value), .fvalue_valid (fvalue_valid),
    .stage_wc_count (stage_wc_count), .stage_threshold (stage_threshold),
    .stage_idx (stage_idx), .wc_idx (wc_idx), .op_done (op_done),
    .busy (busy), .window_done (window_done), .face_detected (face_detected)
  );

  stage_evaluator #(.NUM_STAGES (2)) u_dut2 (
    .clk (clk), .rst (rst), .start (start),
    .feature_value (feature_value), .fvalue_valid (fvalue_valid),
    .stage_wc_count (stage_wc_count), .stage_threshold (stage_threshold),
    .stage_idx (stage_idx2), .wc_idx (wc_idx2), .op_done (op_done2),
    .busy (busy2), .window_done (window_done2), .face_detected (face_detected2)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vote(input logic [15:0] v);
    feature_value = v;
    fvalue_valid  = 1'b1;
    step();
    fvalue_valid  = 1'b0;
  endtask

  task automatic abort_window();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    // ---------------- reset state
    step();
    chk("rst_stage_idx", stage_idx, 0);
    chk("rst_wc_idx", wc_idx, 0);
    chk("rst_op_done", op_done, 1);
    chk("rst_busy", busy, 0);
    chk("rst_window_done", window_done, 0);
    chk("rst_face", face_detected, 0);
    chk("rst_acc", u_dut.acc, 0);
    rst = 1'b0;
    step();

    // ---------------- stage 0 pass: +100 -20 +50 >= 120
    stage_wc_count  = 9'd3;
    stage_threshold = 16'd120;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("s1_busy", busy, 1);
    chk("s1_op_done_low", op_done, 0);
    vote(16'd100);
    chk("s1_acc1", u_dut.acc, 100);
    chk("s1_wc1", wc_idx, 1);
    vote(-16'sd20);
    chk("s1_acc2", u_dut.acc, 80);
    vote(16'd50);
    chk("s1_acc3", u_dut.acc, 130);
    chk("s1_wc3", wc_idx, 3);
    chk("s1_op_done_cmp", op_done, 1);
    chk("s1_busy_cmp", busy, 1);
    step();
    chk("s1_stage_idx", stage_idx, 1);
    chk("s1_wc_clr", wc_idx, 0);
    chk("s1_acc_clr", u_dut.acc, 0);
    chk("s1_op_done_again", op_done, 0);
    chk("s1_no_done", window_done, 0);

    // ---------------- async reset mid-ACCUM
    step();
    rst = 1'b1;
    #1;
    chk("ar_stage_idx", stage_idx, 0);
    chk("ar_op_done", op_done, 1);
    chk("ar_busy", busy, 0);
    chk("ar_acc", u_dut.acc, 0);
    chk("ar_window_done", window_done, 0);
    step();
    chk("ar_window_done_hold", window_done, 0);
    rst = 1'b0;
    step();

    // ---------------- early reject: -300 +100 = -200 < -150
    stage_wc_count  = 9'd2;
    stage_threshold = -16'sd150;
    start = 1'b1;
    step();
    start = 1'b0;
    vote(-16'sd300);
    vote(16'd100);
    chk("rj_acc", u_dut.acc, -200);
    step();
    chk("rj_window_done", window_done, 1);
    chk("rj_face", face_detected, 0);
    chk("rj_op_done", op_done, 1);
    chk("rj_stage_idx", stage_idx, 0);
    chk("rj_busy", busy, 0);
    start = 1'b1;                 // lands on DONE->IDLE edge: ignored
    step();
    start = 1'b0;
    chk("rj_pulse_end", window_done, 0);
    chk("rj_start_ignored", busy, 0);
    step();
    chk("rj_still_idle", busy, 0);

    // ---------------- two-stage cascade, both pass (instance 2)
    stage_wc_count  = 9'd1;
    stage_threshold = 16'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    vote(16'd10);
    chk("fc_cmp0_busy", busy2, 1);
    step();
    chk("fc_stage1", stage_idx2, 1);
    chk("fc_op_done_low", op_done2, 0);
    vote(16'd10);
    chk("fc_cmp1_no_done", window_done2, 0);
    step();
    chk("fc_window_done", window_done2, 1);
    chk("fc_face", face_detected2, 1);
    step();
    chk("fc_pulse_end", window_done2, 0);
    chk("fc_face_held", face_detected2, 1);
    abort_window();

    // ---------------- gaps in valid, start mid-ACCUM ignored
    stage_wc_count  = 9'd2;
    stage_threshold = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    vote(16'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("gp_acc_hold1", u_dut.acc, 5);
    chk("gp_wc_hold1", wc_idx, 1);
    step();
    chk("gp_acc_hold2", u_dut.acc, 5);
    chk("gp_wc_hold2", wc_idx, 1);
    chk("gp_stage_hold", stage_idx, 0);
    vote(16'd7);
    chk("gp_acc", u_dut.acc, 12);
    step();
    chk("gp_pass", stage_idx, 1);
    abort_window();

    // ---------------- empty stage goes straight to COMPARE
    stage_wc_count  = 9'd0;
    stage_threshold = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    fvalue_valid  = 1'b1;
    feature_value = 16'd9;
    step();
    fvalue_valid  = 1'b0;
    chk("em_acc", u_dut.acc, 0);
    chk("em_op_done", op_done, 1);
    step();
    chk("em_pass", stage_idx, 1);
    abort_window();

    // ---------------- positive saturation: 300 x 32767
    stage_wc_count  = 9'd300;
    stage_threshold = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      vote(16'd32767);
      if (i == 255) chk("sat_pre", u_dut.acc, 8388352);
    end
    chk("sat_acc", u_dut.acc, 8388607);
    step();
    chk("sat_pass", stage_idx, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
